// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way picker: round-robin on last_grant, or port 0 fixed priority.
module rr_pick2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_c_o,
  output logic       valid_c_o
);

  always_comb begin
    valid_c_o = |req_i;
    gnt_c_o   = req_i[1];
    if (req_i == 2'b11) begin
      gnt_c_o = FIXED_PRIO ? 1'b0 : ~last_grant_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port data memory: IDLE -> ACCESS -> RESP sequencer
// with a one-cycle ack pulse per access.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DMEM_ADDR_W,
  parameter int unsigned DATA_W     = DMEM_DATA_W,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  mem_req_t          lat_q, lat_d;
  logic              gnt_q, gnt_d;
  logic              last_grant_q, last_grant_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pick_gnt;
  logic              pick_vld;

  rr_pick2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .req_i       ({req1, req0}),
    .last_grant_i(last_grant_q),
    .gnt_c_o     (pick_gnt),
    .valid_c_o   (pick_vld)
  );

  // Next-state and registered-output logic; ack defaults low so it lasts one cycle.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata_d      = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d        = pick_gnt;
          last_grant_d = pick_gnt;
          lat_d.we     = pick_gnt ? we1    : we0;
          lat_d.addr   = pick_gnt ? addr1  : addr0;
          lat_d.wdata  = pick_gnt ? wdata1 : wdata0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (!lat_q.we) begin
          rdata_d = mem_rdata;
        end
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
    end
  end

  // Strobes gated by rst so a reset landing in ACCESS never commits a write.
  assign mem_read  = (state_q == ACCESS) & ~lat_q.we & ~rst;
  assign mem_write = (state_q == ACCESS) &  lat_q.we & ~rst;
  assign mem_addr  = lat_q.addr;
  assign mem_wdata = lat_q.wdata;
  assign busy      = (state_q != IDLE);
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_dmem_arbiter;

  typedef struct {
    logic       port;
    logic [7:0] data;
    logic       chk;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       preload = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic       ack0_rr, ack1_rr, busy_rr, mr_rr, mw_rr;
  logic [7:0] rdata_rr, ma_rr, mwd_rr, mrd_rr;
  logic       ack0_fx, ack1_fx, busy_fx, mr_fx, mw_fx;
  logic [7:0] rdata_fx, ma_fx, mwd_fx, mrd_fx;

  logic [7:0] mem_rr [256];
  logic [7:0] mem_fx [256];

  sb_t sb[$];
  sb_t mon_e;
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_rr), .ack1(ack1_rr), .rdata(rdata_rr), .busy(busy_rr),
    .mem_addr(ma_rr), .mem_wdata(mwd_rr), .mem_read(mr_rr), .mem_write(mw_rr),
    .mem_rdata(mrd_rr)
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1'b1)) u_fx (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_fx), .ack1(ack1_fx), .rdata(rdata_fx), .busy(busy_fx),
    .mem_addr(ma_fx), .mem_wdata(mwd_fx), .mem_read(mr_fx), .mem_write(mw_fx),
    .mem_rdata(mrd_fx)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'hC3;
  endfunction

  // Behavioural 256x8 memories: combinational read, write at the closing edge.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        mem_rr[i] <= init_val(8'(i));
        mem_fx[i] <= init_val(8'(i));
      end
    end else begin
      if (mw_rr) mem_rr[ma_rr] <= mwd_rr;
      if (mw_fx) mem_fx[ma_fx] <= mwd_fx;
    end
  end
  assign mrd_rr = mem_rr[ma_rr];
  assign mrd_fx = mem_fx[ma_fx];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer for the round-robin instance.
  always @(negedge clk) begin
    check("ack_onehot", 32'(ack0_rr & ack1_rr), 32'd0);
    if (ack0_rr | ack1_rr) begin
      if (sb.size() == 0) begin
        check("unexp_ack", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_port", 32'(ack1_rr), 32'(mon_e.port));
        if (mon_e.chk) check("rdata", 32'(rdata_rr), 32'(mon_e.data));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic access(input logic p, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_d, input string tag);
    bit got;
    @(posedge clk); #1;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    sb.push_back('{p, exp_d, ~w});
    got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      check({tag, "_mw"}, 32'(mw_rr), 32'((k == 2) && w));
      check({tag, "_mr"}, 32'(mr_rr), 32'((k == 2) && !w));
      if (k == 2) begin
        check({tag, "_maddr"}, 32'(ma_rr), 32'(a));
        if (w) check({tag, "_mwdata"}, 32'(mwd_rr), 32'(d));
      end
      if (p ? ack1_rr : ack0_rr) begin
        got = 1'b1;
        check({tag, "_lat"}, 32'(k), 32'd3);
        if (p) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n_rr, last, n_fx0, n_fx1, t0, t1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0; preload = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_outs", 32'({ack0_rr, ack1_rr, busy_rr, mr_rr, mw_rr, rdata_rr, ma_rr, mwd_rr}), 32'd0);
    end

    // Port 0 write then read back.
    access(1'b0, 1'b1, 8'h40, 8'hA5, 8'h00, "p0_wr");
    access(1'b0, 1'b0, 8'h40, 8'h00, 8'hA5, "p0_rd");

    // Both ports held: round-robin alternates, fixed priority starves port 1.
    do_reset();
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b0, init_val(8'h10), 1'b1});
      sb.push_back('{1'b1, init_val(8'h20), 1'b1});
    end
    n_rr = 0; last = 0; n_fx0 = 0; n_fx1 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ack0_rr | ack1_rr) begin
        n_rr++;
        if (n_rr > 1) check("rr_gap", 32'(k - last), 32'd3);
        else          check("rr_first", 32'(k), 32'd3);
        last = k;
      end
      if (ack0_fx) n_fx0++;
      if (ack1_fx) n_fx1++;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_acks", 32'(n_rr), 32'd4);
    check("fx_ack0", 32'(n_fx0), 32'd4);
    check("fx_ack1", 32'(n_fx1), 32'd0);
    do_reset();

    // Top address write by port 1, then read it and address 0.
    access(1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, "p1_wr_ff");
    access(1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, "p0_rd_ff");
    access(1'b0, 1'b0, 8'h00, 8'h00, init_val(8'h00), "p0_rd_00");

    // Reset lands in the ACCESS cycle of a port 1 write.
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h80; wdata1 = 8'h3C;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mw", 32'(mw_rr), 32'd0);
    @(posedge clk); #1 rst = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_noack", 32'({ack0_rr, ack1_rr}), 32'd0);
    end
    access(1'b0, 1'b0, 8'h80, 8'h00, init_val(8'h80), "rst_rd80");

    // Port 1 request raised during a port 0 ACCESS waits for IDLE.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
    sb.push_back('{1'b0, 8'hA5, 1'b1});
    sb.push_back('{1'b1, init_val(8'h20), 1'b1});
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    t0 = -1; t1 = -1;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (ack0_rr) begin t0 = k; req0 = 1'b0; end
      if (ack1_rr) begin t1 = k; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("late_ack0", 32'(t0), 32'd3);
    check("late_gap", 32'(t1 - t0), 32'd3);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates one single-port 256x8 data memory between two requesters: port 0 is the CPU datapath and port 1 is a loader/debug/DMA master.
- Sits between the requesters and the data memory's Address/WriteData/MemRead/MemWrite/ReadData pins.
- Serialises accesses through a three-state sequencer with a req/ack handshake.
- Provides round-robin or fixed priority between the two ports.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- FIXED_PRIO, 0. 0 selects round-robin. 1 makes port 0 always win ties.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request; held high until the matching ack.
- we0, we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0, addr1  in  ADDR_W  access address; stable while req is high.
- wdata0, wdata1  in  DATA_W  write data; stable while req is high.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read result; valid in the ack cycle, shared by both ports.
- busy  out  1  high when state is not IDLE.
- mem_addr  out  ADDR_W  to memory Address.
- mem_wdata  out  DATA_W  to memory WriteData.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_rdata  in  DATA_W  from memory ReadData (combinational read).

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset values: state=IDLE, ack0=ack1=0, rdata=0, busy=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, last_grant=1 (so port 0 wins the first tie).
- IDLE:
  - If either req is high, choose the winner and latch its we/addr/wdata plus a grant id at the edge; go to ACCESS.
  - With no req, stay in IDLE.
- Arbitration:
  - Single requester wins unconditionally.
  - Both requesting, FIXED_PRIO=0: the port != last_grant wins.
  - Both requesting, FIXED_PRIO=1: port 0 wins.
  - last_grant updates at the latch edge.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_read = !we_l, mem_write = we_l.
  - At the closing edge, the memory commits the write; rdata <= mem_rdata for reads.
  - For writes, rdata holds its previous value.
  - ack[grant] <= 1; go to RESP.
- RESP (1 cycle):
  - ack[grant]=1 and rdata is valid.
  - mem_read=mem_write=0.
  - Next state is IDLE and ack clears.
  - Requester deasserts req in the RESP cycle, or keeps it high to issue a new access; the new access is sampled in IDLE.
- No arbitration in ACCESS or RESP. A request raised mid-transaction waits.
- Latency: req sampled in cycle t gives ack in cycle t+2. Peak throughput is one access per 3 cycles.
- Outside ACCESS, mem_addr/mem_wdata hold their last latched values and mem_read/mem_write=0.
- Only one ack is ever high. No ack without a prior grant.
- mem_read and mem_write are gated by !rst, so rst asserted during ACCESS suppresses the write.
- Reset mid-operation: the aborted transaction is dropped with no ack, and state returns to IDLE.
- A req dropped before grant is simply not serviced. A req dropped after grant does not cancel the access; ack still pulses.
- Addresses wrap naturally at ADDR_W bits; no range checking.

Decomposition:
- Shared package dmem_pkg holds:
  - ADDR_W/DATA_W defaults.
  - typedef enum logic[1:0] {IDLE, ACCESS, RESP} arb_state_t.
  - typedef struct {we, addr, wdata} mem_req_t.
- One sub-module, rr_pick2: combinational 2-way picker. Inputs are req[1:0], last_grant and FIXED_PRIO; outputs are a grant id and a valid flag.
- The FSM, latches and memory drive stay in dmem_arbiter.

Test Plan:
- Reset then idle: all outputs 0 and busy=0 for 5 cycles with no req.
- Port 0 write then read:
  - Write addr=0x40, data=0xA5: ack0 at t+2 and mem_write high only in the ACCESS cycle.
  - Then read 0x40: rdata=0xA5 with ack0.
- Simultaneous requests, FIXED_PRIO=0:
  - req0 reads 0x10 and req1 reads 0x20, both held.
  - Grants alternate 0,1,0,1; each ack arrives 3 cycles after the previous.
  - Repeat with FIXED_PRIO=1: port 1 is never served while req0 is held.
- Port 1 write 0xFF->addr 0xFF then port 0 read 0xFF: rdata=0xFF; address 0x00 is unchanged (no wrap corruption).
- Reset in ACCESS:
  - Port 1 writes 0x3C to 0x80 with rst=1 in the ACCESS cycle.
  - No ack1; mem_write=0; a later read of 0x80 returns the old value.
- Late request: req1 rises during a port 0 ACCESS cycle, so it is not granted until IDLE and ack1 arrives exactly 3 cycles after ack0.
